// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet-granular Avalon-ST arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY)
//   STAT_WIDTH  : width of each statistics counter
//   sel_width() : width of a source index for a given source count
package pkt_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned STAT_WIDTH = 16;

   // A two-source arbiter still needs one index bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
//   req_i        : request vector, one bit per source
//   last_grant_i : index granted most recently; search starts one above it
//   winner_o     : first requesting index found, wrapping modulo NUM_SRC
//   found_o      : at least one request was present
module rr_arbiter
   import pkt_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned SEL_WIDTH = sel_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0]   req_i,
   input  logic [SEL_WIDTH-1:0] last_grant_i,
   output logic [SEL_WIDTH-1:0] winner_o,
   output logic                 found_o
);

   always_comb begin
      int unsigned idx;
      idx      = 0;
      winner_o = '0;
      found_o  = 1'b0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         idx = (32'(last_grant_i) + i) % NUM_SRC;
         if (!found_o && req_i[idx]) begin
            winner_o = SEL_WIDTH'(idx);
            found_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ast_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC Avalon-ST sources.
// A grant is taken on a startofpacket request and held until the granted
// source's endofpacket beat is accepted; one bubble cycle per packet.
// Ports:
//   clk_i, srst_n_i      : clock, synchronous active-low reset
//   arb_en_i             : permits new grants (an active packet always completes)
//   sink_*_i/sink_ready_o: per-source Avalon-ST sinks, source k in slice k
//   src_*_o/src_ready_i  : merged Avalon-ST source, src_channel_o = grant index
//   busy_o               : a packet grant is active
//   drop_o               : pulse when out-of-packet beats are discarded in IDLE
// Optional (macro PKT_ARB_STATS_EN):
//   pkt_cnt_o            : per-source saturating count of accepted eop beats
//   drop_cnt_o           : saturating count of drop_o pulses
module ast_pkt_arbiter
   import pkt_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned AST_DWIDTH  = 64,
   parameter int unsigned EMPTY_WIDTH = $clog2(AST_DWIDTH/8),
   parameter int unsigned SEL_WIDTH   = sel_width(NUM_SRC)
) (
   input  logic                           clk_i,
   input  logic                           srst_n_i,
   input  logic                           arb_en_i,
   input  logic [NUM_SRC*AST_DWIDTH-1:0]  sink_data_i,
   input  logic [NUM_SRC-1:0]             sink_valid_i,
   input  logic [NUM_SRC-1:0]             sink_sop_i,
   input  logic [NUM_SRC-1:0]             sink_eop_i,
   input  logic [NUM_SRC*EMPTY_WIDTH-1:0] sink_empty_i,
   output logic [NUM_SRC-1:0]             sink_ready_o,
   output logic [AST_DWIDTH-1:0]          src_data_o,
   output logic                           src_valid_o,
   output logic                           src_sop_o,
   output logic                           src_eop_o,
   output logic [EMPTY_WIDTH-1:0]         src_empty_o,
   output logic [SEL_WIDTH-1:0]           src_channel_o,
   input  logic                           src_ready_i,
`ifdef PKT_ARB_STATS_EN
   output logic [NUM_SRC*STAT_WIDTH-1:0]  pkt_cnt_o,
   output logic [STAT_WIDTH-1:0]          drop_cnt_o,
`endif
   output logic                           busy_o,
   output logic                           drop_o
);

   arb_state_e           state_q, state_d;
   logic [SEL_WIDTH-1:0] grant_q, grant_d;
   logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;

   logic [NUM_SRC-1:0]     req, orphan;
   logic [SEL_WIDTH-1:0]   winner;
   logic                   found;
   logic                   sel_valid, sel_sop, sel_eop;
   logic [AST_DWIDTH-1:0]  sel_data;
   logic [EMPTY_WIDTH-1:0] sel_empty;
   logic                   eop_acc;

   assign req    = sink_valid_i & sink_sop_i;
   assign orphan = sink_valid_i & ~sink_sop_i;

   rr_arbiter #(
      .NUM_SRC   (NUM_SRC),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr_arbiter (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .winner_o     (winner),
      .found_o      (found)
   );

   // Zero-latency mux of the granted source.
   always_comb begin
      sel_valid = 1'b0;
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      sel_data  = '0;
      sel_empty = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (grant_q == SEL_WIDTH'(k)) begin
            sel_valid = sink_valid_i[k];
            sel_sop   = sink_sop_i[k];
            sel_eop   = sink_eop_i[k];
            sel_data  = sink_data_i[k*AST_DWIDTH +: AST_DWIDTH];
            sel_empty = sink_empty_i[k*EMPTY_WIDTH +: EMPTY_WIDTH];
         end
      end
   end

   assign src_data_o    = sel_data;
   assign src_empty_o   = sel_empty;
   assign src_channel_o = grant_q;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      sink_ready_o = '0;
      src_valid_o  = 1'b0;
      src_sop_o    = 1'b0;
      src_eop_o    = 1'b0;
      busy_o       = 1'b0;
      drop_o       = 1'b0;
      case (state_q)
         IDLE: begin
            // Out-of-packet beats are drained so they cannot block a sop.
            sink_ready_o = orphan;
            drop_o       = |orphan;
            if (arb_en_i && found) begin
               grant_d      = winner;
               last_grant_d = winner;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            busy_o       = 1'b1;
            src_valid_o  = sel_valid;
            src_sop_o    = sel_sop;
            src_eop_o    = sel_eop;
            sink_ready_o = {{(NUM_SRC-1){1'b0}}, src_ready_i} << grant_q;
         end
         default: state_d = IDLE;
      endcase
      // No handshakes while reset is held, whatever the pre-reset state.
      if (!srst_n_i) begin
         sink_ready_o = '0;
         src_valid_o  = 1'b0;
         src_sop_o    = 1'b0;
         src_eop_o    = 1'b0;
         busy_o       = 1'b0;
         drop_o       = 1'b0;
      end
      eop_acc = src_valid_o & src_ready_i & src_eop_o;
      if (eop_acc) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= SEL_WIDTH'(NUM_SRC-1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef PKT_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] pkt_cnt_q [NUM_SRC];
   logic [STAT_WIDTH-1:0] pkt_cnt_d [NUM_SRC];
   logic [STAT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         pkt_cnt_d[k] = pkt_cnt_q[k];
         if (eop_acc && grant_q == SEL_WIDTH'(k) && pkt_cnt_q[k] != '1) begin
            pkt_cnt_d[k] = pkt_cnt_q[k] + STAT_WIDTH'(1);
         end
         pkt_cnt_o[k*STAT_WIDTH +: STAT_WIDTH] = pkt_cnt_q[k];
      end
      drop_cnt_d = drop_cnt_q;
      if (drop_o && drop_cnt_q != '1) begin
         drop_cnt_d = drop_cnt_q + STAT_WIDTH'(1);
      end
   end

   assign drop_cnt_o = drop_cnt_q;

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            pkt_cnt_q[k] <= '0;
         end
         drop_cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            pkt_cnt_q[k] <= pkt_cnt_d[k];
         end
         drop_cnt_q <= drop_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_ast_pkt_arbiter.sv
// Self-checking bench for ast_pkt_arbiter (NUM_SRC=4, AST_DWIDTH=64).
// Per-source beat queues drive the sinks; a cycle reference model derived
// from the arbitration rules predicts every output. Build with
// PKT_ARB_STATS_EN defined to also check the statistics counters.
module tb_ast_pkt_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int EW = 3;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            srst_n, arb_en, src_ready;
   logic [N*DW-1:0] sink_data;
   logic [N-1:0]    sink_valid, sink_sop, sink_eop, sink_ready;
   logic [N*EW-1:0] sink_empty;
   logic [DW-1:0]   src_data;
   logic            src_valid, src_sop, src_eop, busy, drop;
   logic [EW-1:0]   src_empty;
   logic [SW-1:0]   src_channel;
`ifdef PKT_ARB_STATS_EN
   logic [N*16-1:0] pkt_cnt;
   logic [15:0]     drop_cnt;
`endif

   ast_pkt_arbiter #(
      .NUM_SRC    (N),
      .AST_DWIDTH (DW)
   ) dut (
      .clk_i         (clk),
      .srst_n_i      (srst_n),
      .arb_en_i      (arb_en),
      .sink_data_i   (sink_data),
      .sink_valid_i  (sink_valid),
      .sink_sop_i    (sink_sop),
      .sink_eop_i    (sink_eop),
      .sink_empty_i  (sink_empty),
      .sink_ready_o  (sink_ready),
      .src_data_o    (src_data),
      .src_valid_o   (src_valid),
      .src_sop_o     (src_sop),
      .src_eop_o     (src_eop),
      .src_empty_o   (src_empty),
      .src_channel_o (src_channel),
      .src_ready_i   (src_ready),
`ifdef PKT_ARB_STATS_EN
      .pkt_cnt_o     (pkt_cnt),
      .drop_cnt_o    (drop_cnt),
`endif
      .busy_o        (busy),
      .drop_o        (drop)
   );

   typedef struct {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
   } beat_t;

   typedef struct {
      int          ch;
      logic        sop;
      logic        eop;
      logic [63:0] data;
   } obeat_t;

   beat_t  src_q [N][$];
   obeat_t out_log[$];
   int     chan_log[$];
   int     gap_log[$];

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus knobs
   int valid_prob = 100;
   int rdy_prob   = 100;
   int rdy_pat[$];
   bit en_v       = 1'b1;
   bit en_rand    = 1'b0;

   // reference model state
   bit m_busy  = 1'b0;
   int m_grant = 0;
   int m_last  = N-1;
   int m_pkt[N];
   int m_drop  = 0;

   // observed from DUT
   int dut_pkts[N];
   int dut_drops;
   int cyc = 0;
   int last_rise = -1;
   int idle_run = 0;
   bit prev_busy = 1'b0;
   bit seen_busy = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic clear_tallies();
      out_log.delete();
      chan_log.delete();
      gap_log.delete();
      for (int k = 0; k < N; k++) dut_pkts[k] = 0;
      dut_drops = 0;
      idle_run  = 0;
      prev_busy = 1'b0;
      seen_busy = 1'b0;
   endtask

   task automatic add_pkt(input int k, input int len, input logic [63:0] base, input bit mid_sop);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data  = base + 64'(i);
         b.sop   = (i == 0) || (mid_sop && i == 1 && len > 2);
         b.eop   = (i == len-1);
         b.empty = b.eop ? 3'($urandom_range(7)) : 3'd0;
         src_q[k].push_back(b);
      end
   endtask

   task automatic add_orphan(input int k);
      beat_t b;
      b.data  = {8'(k), 8'hEE, 48'($urandom)};
      b.sop   = 1'b0;
      b.eop   = 1'($urandom);
      b.empty = 3'd0;
      src_q[k].push_back(b);
   endtask

   // One clock cycle: drive at negedge, check at negedge+1, model steps at posedge.
   task automatic step();
      logic [N-1:0]  v, s, e, exp_rdy;
      logic [63:0]   d [N];
      logic [2:0]    em [N];
      logic          rdy, exp_drop, acc;
      int            g, nxt, c;
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() > 0 && $urandom_range(99) < valid_prob) begin
            v[k] = 1'b1;  d[k] = src_q[k][0].data;  s[k] = src_q[k][0].sop;
            e[k] = src_q[k][0].eop;  em[k] = src_q[k][0].empty;
         end else begin
            v[k] = 1'b0;  d[k] = {$urandom, $urandom};  s[k] = 1'($urandom);
            e[k] = 1'($urandom);  em[k] = 3'($urandom);
         end
         sink_data[k*DW +: DW]  = d[k];
         sink_empty[k*EW +: EW] = em[k];
      end
      sink_valid = v;  sink_sop = s;  sink_eop = e;
      rdy = (rdy_pat.size() > 0) ? 1'(rdy_pat.pop_front()) : ($urandom_range(99) < rdy_prob);
      src_ready = rdy;
      arb_en = en_rand ? 1'($urandom) : en_v;
      #1;
      exp_rdy = '0;  exp_drop = 1'b0;  acc = 1'b0;  nxt = -1;  g = m_grant;
      if (!srst_n) begin
         check("rst_busy",  64'(busy),       64'(0));
         check("rst_valid", 64'(src_valid),  64'(0));
         check("rst_ready", 64'(sink_ready), 64'(0));
         check("rst_drop",  64'(drop),       64'(0));
      end else if (!m_busy) begin
         exp_rdy  = v & ~s;
         exp_drop = |exp_rdy;
         check("idle_busy",  64'(busy),        64'(0));
         check("idle_valid", 64'(src_valid),   64'(0));
         check("idle_ready", 64'(sink_ready),  64'(exp_rdy));
         check("idle_drop",  64'(drop),        64'(exp_drop));
         check("idle_chan",  64'(src_channel), 64'(m_grant));
         if (arb_en) begin
            for (int j = 1; j <= N; j++) begin
               c = (m_last + j) % N;
               if (nxt < 0 && v[c] && s[c]) nxt = c;
            end
         end
      end else begin
         exp_rdy[g] = rdy;
         check("busy_busy",  64'(busy),        64'(1));
         check("busy_valid", 64'(src_valid),   64'(v[g]));
         check("busy_ready", 64'(sink_ready),  64'(exp_rdy));
         check("busy_drop",  64'(drop),        64'(0));
         check("busy_chan",  64'(src_channel), 64'(g));
         if (v[g]) begin
            check("data",  src_data,       d[g]);
            check("sop",   64'(src_sop),   64'(s[g]));
            check("eop",   64'(src_eop),   64'(e[g]));
            check("empty", 64'(src_empty), 64'(em[g]));
         end
         acc = v[g] && rdy && e[g];
      end
`ifdef PKT_ARB_STATS_EN
      for (int k = 0; k < N; k++) begin
         check($sformatf("pkt_cnt%0d", k), 64'(pkt_cnt[k*16 +: 16]), 64'(m_pkt[k]));
      end
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
      // tallies observed at the DUT outputs
      if (src_valid && src_ready) begin
         out_log.push_back('{ch: int'(src_channel), sop: src_sop, eop: src_eop, data: src_data});
         if (src_eop) dut_pkts[src_channel]++;
      end
      if (drop) dut_drops++;
      if (busy) begin
         if (!prev_busy && seen_busy) gap_log.push_back(idle_run);
         if (!prev_busy) begin
            chan_log.push_back(int'(src_channel));
            last_rise = cyc;
         end
         seen_busy = 1'b1;
         idle_run  = 0;
      end else begin
         idle_run++;
      end
      prev_busy = busy;
      // model state advance
      for (int k = 0; k < N; k++) begin
         if (v[k] && exp_rdy[k]) void'(src_q[k].pop_front());
      end
      if (!srst_n) begin
         m_busy = 1'b0;  m_grant = 0;  m_last = N-1;  m_drop = 0;
         for (int k = 0; k < N; k++) m_pkt[k] = 0;
      end else if (!m_busy) begin
         if (exp_drop && m_drop < 65535) m_drop++;
         if (nxt >= 0) begin
            m_busy = 1'b1;  m_grant = nxt;  m_last = nxt;
         end
      end else if (acc) begin
         if (m_pkt[g] < 65535) m_pkt[g]++;
         m_busy = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain(input int max_cyc);
      int cnt;
      bit pending;
      cnt = 0;
      forever begin
         pending = m_busy;
         for (int k = 0; k < N; k++) if (src_q[k].size() > 0) pending = 1'b1;
         if (!pending) break;
         if (cnt >= max_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d cycles without emptying, required completion", cnt);
            for (int k = 0; k < N; k++) src_q[k].delete();
            break;
         end
         step();
         cnt++;
      end
   endtask

   task automatic do_reset();
      srst_n = 1'b0;
      step();
      step();
      srst_n = 1'b1;
      rdy_pat.delete();
      clear_tallies();
   endtask

   // Every output beat must belong to its channel and packets must not interleave.
   task automatic check_stream();
      int cur;
      cur = -1;
      foreach (out_log[i]) begin
         check("stream_src", 64'(out_log[i].data[63:56]), 64'(out_log[i].ch));
         if (cur < 0) check("stream_sop", 64'(out_log[i].sop), 64'(1));
         else         check("interleave", 64'(out_log[i].ch), 64'(cur));
         cur = out_log[i].eop ? -1 : out_log[i].ch;
      end
   endtask

   initial begin
      int exp_order[5];
      int n_gen, k, sop_cyc;
      exp_order = '{0, 1, 2, 3, 0};
      srst_n = 1'b0;  arb_en = 1'b0;  src_ready = 1'b0;
      sink_data = '0;  sink_valid = '0;  sink_sop = '0;  sink_eop = '0;  sink_empty = '0;
      for (int i = 0; i < N; i++) m_pkt[i] = 0;
      @(negedge clk);
      do_reset();

      // reset state
      check("reset_busy",  64'(busy),        64'(0));
      check("reset_valid", 64'(src_valid),   64'(0));
      check("reset_ready", 64'(sink_ready),  64'(0));
      check("reset_drop",  64'(drop),        64'(0));
      check("reset_chan",  64'(src_channel), 64'(0));

      // source 2 sends a 3-beat packet
      sop_cyc = cyc;
      add_pkt(2, 3, 64'hA0, 1'b0);
      drain(50);
      check("t1_busy_latency", 64'(last_rise - sop_cyc), 64'(1));
      check("t1_beats", 64'(out_log.size()), 64'(3));
      for (int i = 0; i < 3 && i < out_log.size(); i++) begin
         check("t1_data", out_log[i].data,        64'hA0 + 64'(i));
         check("t1_chan", 64'(out_log[i].ch),     64'(2));
         check("t1_sop",  64'(out_log[i].sop),    64'(i == 0));
         check("t1_eop",  64'(out_log[i].eop),    64'(i == 2));
      end
      check("t1_idle_after", 64'(busy), 64'(0));

      // fairness: all sources continuously requesting 2-beat packets
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int j = 0; j < N; j++) add_pkt(j, 2, {8'(j), 24'(r), 32'h0}, 1'b0);
      drain(200);
      check("fair_count", 64'(chan_log.size()), 64'(8));
      for (int i = 0; i < 5 && i < chan_log.size(); i++)
         check($sformatf("fair_order%0d", i), 64'(chan_log[i]), 64'(exp_order[i]));
      check("fair_gaps", 64'(gap_log.size()), 64'(7));
      foreach (gap_log[i]) check("fair_bubble", 64'(gap_log[i]), 64'(1));
      check_stream();

      // backpressure on source 1, others waiting
      clear_tallies();
      add_pkt(1, 4, 64'hB0, 1'b0);
      add_pkt(2, 2, 64'hC0, 1'b0);
      add_orphan(3);
      rdy_pat = '{1, 1, 0, 0, 1, 1, 1};
      drain(100);
      check("t3_beats", 64'(out_log.size()), 64'(6));
      for (int i = 0; i < 4 && i < out_log.size(); i++) begin
         check("t3_data", out_log[i].data,    64'hB0 + 64'(i));
         check("t3_chan", 64'(out_log[i].ch), 64'(1));
      end
      check("t3_drops", 64'(dut_drops), 64'(1));

      // orphan beats in IDLE
      clear_tallies();
      add_orphan(3);
      add_orphan(3);
      run(2);
      check("t4_drops", 64'(dut_drops), 64'(2));
      check("t4_out",   64'(out_log.size()), 64'(0));

      // arb_en deasserted during a packet
      clear_tallies();
      add_pkt(0, 4, 64'hD0, 1'b0);
      step();
      en_v = 1'b0;
      add_pkt(1, 2, 64'hE0, 1'b0);
      run(12);
      check("t5_pkt0", 64'(dut_pkts[0]), 64'(1));
      check("t5_pkt1_held", 64'(dut_pkts[1]), 64'(0));
      check("t5_idle", 64'(busy), 64'(0));
      en_v = 1'b1;
      drain(50);
      check("t5_pkt1", 64'(dut_pkts[1]), 64'(1));

      // reset mid-packet: tail beats become orphans
      do_reset();
      add_pkt(1, 6, 64'hF0, 1'b0);
      run(3);
      srst_n = 1'b0;
      step();
      srst_n = 1'b1;
      drain(50);
      check("t7_out",   64'(out_log.size()), 64'(2));
      check("t7_pkts",  64'(dut_pkts[1]),    64'(0));
      check("t7_drops", 64'(dut_drops),      64'(4));

      // statistics: 5 packets and 1 orphan from source 0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         add_pkt(0, 1 + i % 3, {8'h0, 24'(i), 32'h0}, 1'b0);
         if (i == 2) add_orphan(0);
      end
      drain(100);
      check("t6_pkts",  64'(dut_pkts[0]), 64'(5));
      check("t6_drops", 64'(dut_drops),   64'(1));
`ifdef PKT_ARB_STATS_EN
      check("t6_pkt_cnt",  64'(pkt_cnt[15:0]), 64'(5));
      check("t6_drop_cnt", 64'(drop_cnt),      64'(1));
`endif

      // randomized traffic
      do_reset();
      en_rand = 1'b1;
      valid_prob = 75;
      rdy_prob = 75;
      n_gen = 200;
      for (int i = 0; i < n_gen; i++) begin
         k = int'($urandom_range(N-1));
         if ($urandom_range(99) < 15) add_orphan(k);
         add_pkt(k, int'($urandom_range(1, 5)), {8'(k), 24'(i), 32'h0}, $urandom_range(99) < 10);
      end
      drain(30000);
      check("rand_pkts", 64'(dut_pkts[0] + dut_pkts[1] + dut_pkts[2] + dut_pkts[3]), 64'(n_gen));
      check_stream();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
